// File: rtl/door_alarm_ctrl.sv
// door_alarm_ctrl: per-door 2-flop synchroniser and debouncer, an unmasked
// "any door open" light, and an arm/grace/alarm state machine with an
// entry-grace timer.
// Optional build macro: ALL_OPEN_ALARM_EN. When defined, every door reading
// open (mask ignored) in ARMED or GRACE forces ALARM on the next edge,
// bypassing the grace timer.
// Request semantics: arm and disarm are sampled on every rising edge. They
// may be single-cycle pulses or held levels, and no acknowledge is returned.
// disarm always wins when both requests are high.
module door_alarm_ctrl #(
  parameter int NUM_DOORS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OPEN_TIMEOUT    = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_DOORS-1:0] door_raw,
  input  logic [NUM_DOORS-1:0] door_mask,
  input  logic                 arm,
  input  logic                 disarm,
  output logic [NUM_DOORS-1:0] door_stable,
  output logic                 light,
  output logic                 alarm,
  output logic [NUM_DOORS-1:0] alarm_src,
  output logic [1:0]           state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_GRACE    = 2'b10,
    ST_ALARM    = 2'b11
  } state_t;

  logic [NUM_DOORS-1:0] r_sync1;
  logic [NUM_DOORS-1:0] r_sync2;
  logic [CNT_W-1:0]     r_db_cnt [NUM_DOORS];
  logic [NUM_DOORS-1:0] r_door_stable;
  logic                 r_light;
  state_t               r_state;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_alarm;
  logic [NUM_DOORS-1:0] r_alarm_src;

  state_t               w_state_nxt;
  logic [TMR_W-1:0]     w_timer_nxt;
  logic [NUM_DOORS-1:0] w_alarm_src_nxt;
  logic [NUM_DOORS-1:0] w_open_vec;
  logic                 w_open_any;
  logic                 w_all_open;

  // Doors that count toward the light and the state machine.
  assign w_open_vec = r_door_stable & ~door_mask;
  assign w_open_any = |w_open_vec;

`ifdef ALL_OPEN_ALARM_EN
  assign w_all_open = &r_door_stable;
`else
  assign w_all_open = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous contact inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= door_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-door debounce: accept a change only after it has persisted long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DOORS; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_door_stable <= '0;
    end else begin
      for (int i = 0; i < NUM_DOORS; i++) begin
        if (r_sync2[i] != r_door_stable[i]) begin
          if (r_db_cnt[i] == CNT_LAST) begin
            r_door_stable[i] <= ~r_door_stable[i];
            r_db_cnt[i]      <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Light is the registered OR of unmasked debounced doors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_light <= 1'b0;
    end else begin
      r_light <= w_open_any;
    end
  end

  // Next-state, grace timer and alarm source; disarm is checked first everywhere.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_alarm_src_nxt = r_alarm_src;
    case (r_state)
      ST_DISARMED: begin
        if (!disarm && arm && !w_open_any) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          w_state_nxt = ST_DISARMED;
        end else if (w_all_open) begin
          w_state_nxt = ST_ALARM;
        end else if (w_open_any) begin
          w_state_nxt = ST_GRACE;
          w_timer_nxt = TMR_LOAD;
        end
      end
      ST_GRACE: begin
        if (disarm) begin
          w_state_nxt = ST_DISARMED;
        end else if (w_all_open) begin
          w_state_nxt = ST_ALARM;
        end else if (!w_open_any) begin
          w_state_nxt = ST_ARMED;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_ALARM;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_ALARM: begin
        if (disarm) begin
          w_state_nxt = ST_DISARMED;
        end
      end
      default: begin
        w_state_nxt = ST_DISARMED;
      end
    endcase

    // Load on alarm entry, accumulate while in alarm, clear when disarmed.
    if (w_state_nxt == ST_ALARM) begin
      if (r_state == ST_ALARM) begin
        w_alarm_src_nxt = r_alarm_src | w_open_vec;
      end else begin
        w_alarm_src_nxt = w_open_vec;
      end
    end else if (w_state_nxt == ST_DISARMED && r_state != ST_DISARMED) begin
      w_alarm_src_nxt = '0;
    end
  end

  // State, timer, alarm flag and alarm source registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_DISARMED;
      r_timer     <= '0;
      r_alarm     <= 1'b0;
      r_alarm_src <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_alarm     <= (w_state_nxt == ST_ALARM);
      r_alarm_src <= w_alarm_src_nxt;
    end
  end

  assign door_stable = r_door_stable;
  assign light       = r_light;
  assign alarm       = r_alarm;
  assign alarm_src   = r_alarm_src;
  assign state       = r_state;

endmodule

// File: tb/tb_door_alarm_ctrl.sv
// Bench for door_alarm_ctrl: directed stimulus, a behavioural reference model
// updated every rising edge, a per-cycle compare process and literal checks.
module tb_door_alarm_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int TO  = 8;

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARM = 2'd1;
  localparam logic [1:0] S_GRC = 2'd2;
  localparam logic [1:0] S_ALM = 2'd3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] door_raw = '0;
  logic [N-1:0] door_mask = '0;
  logic         arm = 1'b0;
  logic         disarm = 1'b0;
  logic [N-1:0] door_stable;
  logic         light;
  logic         alarm;
  logic [N-1:0] alarm_src;
  logic [1:0]   state;

  always #5 clk = ~clk;

  door_alarm_ctrl #(
    .NUM_DOORS      (N),
    .DEBOUNCE_CYCLES(DEB),
    .OPEN_TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .door_raw   (door_raw),
    .door_mask  (door_mask),
    .arm        (arm),
    .disarm     (disarm),
    .door_stable(door_stable),
    .light      (light),
    .alarm      (alarm),
    .alarm_src  (alarm_src),
    .state      (state)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // raw_q holds raw samples of the last two edges (what the synchroniser
  // presents two edges later); sync_q holds the last DEB synchronised samples.
  // A door is accepted as changed once all DEB recent samples disagree with it.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] sync_q[$];
  logic [N-1:0] m_stable = '0;
  logic         m_light = 1'b0;
  logic         m_alarm = 1'b0;
  logic [N-1:0] m_src = '0;
  logic [1:0]   m_state = S_DIS;
  int           m_grace = 0;

  logic [N-1:0] md_sync, md_old, md_new, md_open;
  logic [1:0]   md_nst;
  bit           md_all, md_diff;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        raw_q.delete();
        sync_q.delete();
        m_stable = '0;
        m_light  = 1'b0;
        m_alarm  = 1'b0;
        m_src    = '0;
        m_state  = S_DIS;
        m_grace  = 0;
      end else begin
        md_sync = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
        raw_q.push_back(door_raw);
        if (raw_q.size() > 2) void'(raw_q.pop_front());
        sync_q.push_back(md_sync);
        if (sync_q.size() > DEB) void'(sync_q.pop_front());

        md_old = m_stable;
        md_new = m_stable;
        for (int i = 0; i < N; i++) begin
          if (sync_q.size() == DEB) begin
            md_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
              if (sync_q[k][i] == md_old[i]) md_diff = 1'b0;
            end
            if (md_diff) md_new[i] = ~md_old[i];
          end
        end

        md_open = md_old & ~door_mask;
        m_light = |md_open;
`ifdef ALL_OPEN_ALARM_EN
        md_all = &md_old;
`else
        md_all = 1'b0;
`endif
        md_nst = m_state;
        if (disarm) begin
          md_nst = S_DIS;
        end else begin
          case (m_state)
            S_DIS: if (arm && md_open == '0) md_nst = S_ARM;
            S_ARM: begin
              if (md_all) md_nst = S_ALM;
              else if (md_open != '0) begin
                md_nst  = S_GRC;
                m_grace = 0;
              end
            end
            S_GRC: begin
              if (md_all) md_nst = S_ALM;
              else if (md_open == '0) md_nst = S_ARM;
              else begin
                m_grace++;
                if (m_grace == TO) md_nst = S_ALM;
              end
            end
            default: md_nst = S_ALM;
          endcase
        end

        if (md_nst == S_ALM) m_src = (m_state == S_ALM) ? (m_src | md_open) : md_open;
        else if (md_nst == S_DIS) m_src = '0;
        m_alarm  = (md_nst == S_ALM);
        m_state  = md_nst;
        m_stable = md_new;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("cyc_door_stable", door_stable, m_stable);
        cmp("cyc_light", light, m_light);
        cmp("cyc_alarm", alarm, m_alarm);
        cmp("cyc_alarm_src", alarm_src, m_src);
        cmp("cyc_state", state, m_state);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cyc(3);
    cmp("rst_state", state, S_DIS);
    cmp("rst_stable", door_stable, 4'b0000);
    cmp("rst_light", light, 1'b0);
    cmp("rst_alarm", alarm, 1'b0);
    cmp("rst_src", alarm_src, 4'b0000);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc(2);

    // Debounce: short glitch rejected, held edge accepted at edge 6.
    door_raw = 4'b0001;
    cyc(3);
    door_raw = 4'b0000;
    cyc(10);
    cmp("glitch_stable", door_stable, 4'b0000);
    cmp("glitch_light", light, 1'b0);
    door_raw = 4'b0100;
    cyc(5);
    cmp("db_edge5_stable", door_stable, 4'b0000);
    cyc(1);
    cmp("db_edge6_stable", door_stable, 4'b0100);
    cmp("db_edge6_light", light, 1'b0);
    cyc(1);
    cmp("db_edge7_light", light, 1'b1);
    door_raw = 4'b0000;
    cyc(8);

    // Grace to alarm.
    pulse_arm();
    cmp("arm_state", state, S_ARM);
    door_raw = 4'b0010;
    cyc(6);
    cmp("g_stable", door_stable, 4'b0010);
    cmp("g_still_armed", state, S_ARM);
    cyc(1);
    cmp("g_enter", state, S_GRC);
    cyc(7);
    cmp("g_edge7_state", state, S_GRC);
    cmp("g_edge7_alarm", alarm, 1'b0);
    cyc(1);
    cmp("g_edge8_state", state, S_ALM);
    cmp("g_edge8_alarm", alarm, 1'b1);
    cmp("g_edge8_src", alarm_src, 4'b0010);
    door_raw = 4'b1010;
    cyc(7);
    cmp("g_src_or", alarm_src, 4'b1010);
    door_raw = 4'b0000;
    cyc(8);
    cmp("alarm_sticky_state", state, S_ALM);
    cmp("alarm_sticky_src", alarm_src, 4'b1010);
    pulse_disarm();
    cmp("disarm_state", state, S_DIS);
    cmp("disarm_src", alarm_src, 4'b0000);
    cmp("disarm_alarm", alarm, 1'b0);

    // Grace abort by disarm on the 5th grace cycle.
    pulse_arm();
    door_raw = 4'b0010;
    cyc(7);
    cmp("ab_enter", state, S_GRC);
    cyc(4);
    pulse_disarm();
    cmp("ab_state", state, S_DIS);
    cmp("ab_alarm", alarm, 1'b0);
    pulse_arm();
    cmp("arm_door_open_ignored", state, S_DIS);
    door_raw = 4'b0000;
    cyc(8);

    // Door closes during grace -> back to ARMED.
    pulse_arm();
    door_raw = 4'b0010;
    cyc(7);
    cmp("cl_enter", state, S_GRC);
    door_raw = 4'b0000;
    cyc(6);
    cmp("cl_edge6", state, S_GRC);
    cyc(1);
    cmp("cl_rearmed", state, S_ARM);
    cmp("cl_alarm", alarm, 1'b0);

    // arm and disarm together in ARMED.
    arm = 1'b1;
    disarm = 1'b1;
    cyc(1);
    arm = 1'b0;
    disarm = 1'b0;
    cmp("both_state", state, S_DIS);

    // Masked door ignored while armed.
    pulse_arm();
    cmp("mask_arm", state, S_ARM);
    door_mask = 4'b1000;
    door_raw = 4'b1000;
    cyc(10);
    cmp("mask_state", state, S_ARM);
    cmp("mask_light", light, 1'b0);
    cmp("mask_stable", door_stable, 4'b1000);
    door_raw = 4'b0000;
    cyc(8);
    door_mask = 4'b0000;

    // arm with door0 open in DISARMED: first disarm, then try.
    pulse_disarm();
    door_raw = 4'b0001;
    cyc(8);
    pulse_arm();
    cmp("arm_door0_open", state, S_DIS);
    door_raw = 4'b0000;
    cyc(8);

    // Asynchronous reset in ALARM.
    pulse_arm();
    door_raw = 4'b0011;
    cyc(7);
    cmp("r_enter_grace", state, S_GRC);
    cyc(8);
    cmp("r_alarm_state", state, S_ALM);
    cmp("r_alarm_src", alarm_src, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_state", state, S_DIS);
    cmp("async_alarm", alarm, 1'b0);
    cmp("async_src", alarm_src, 4'b0000);
    cmp("async_stable", door_stable, 4'b0000);
    cmp("async_light", light, 1'b0);
    cyc(1);
    door_raw = 4'b0000;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // All doors open.
    pulse_arm();
    cmp("ao_arm", state, S_ARM);
    door_raw = 4'b1111;
    cyc(6);
    cmp("ao_stable", door_stable, 4'b1111);
    cmp("ao_armed", state, S_ARM);
    cyc(1);
`ifdef ALL_OPEN_ALARM_EN
    cmp("ao_bypass_state", state, S_ALM);
    cmp("ao_bypass_src", alarm_src, 4'b1111);
`else
    cmp("ao_grace", state, S_GRC);
    cyc(7);
    cmp("ao_grace_edge7", state, S_GRC);
    cyc(1);
    cmp("ao_alarm_state", state, S_ALM);
    cmp("ao_alarm_src", alarm_src, 4'b1111);
`endif
    pulse_disarm();
    cmp("ao_disarm", state, S_DIS);
    door_raw = 4'b0000;
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/door_alarm_ctrl.md
Name: door_alarm_ctrl

Overview:
- Parametrised, clocked successor to the combinational door-light monitor.
- Per-door input synchroniser and debouncer, an unmasked "any door open" light, and an arm/grace/alarm state machine with a programmable entry-grace timer.
- Sits between raw door-contact pins and the annunciator/status logic.

Parameters:
- NUM_DOORS, 4, number of door channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a door change (>=1).
- OPEN_TIMEOUT, 1000, cycles a door may stay open while armed before alarm (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- door_raw  input  NUM_DOORS  raw contact per door, 1 = open; asynchronous to clk.
- door_mask  input  NUM_DOORS  1 = door excluded from light and FSM decisions; synchronous.
- arm  input  1  single-cycle or level arm request.
- disarm  input  1  single-cycle or level disarm request.
- door_stable  output  NUM_DOORS  debounced door state.
- light  output  1  registered OR of (door_stable & ~door_mask).
- alarm  output  1  high only in ALARM.
- alarm_src  output  NUM_DOORS  sticky record of unmasked doors open during alarm.
- state  output  2  DISARMED=00, ARMED=01, GRACE=10, ALARM=11.

Behaviour:
- Reset (async, rst_n=0) clears all flops immediately:
  - door_stable=0, light=0, alarm=0, alarm_src=0, state=DISARMED.
  - Synchroniser, debounce counters and timer are cleared.
- Reset mid-operation is legal in any state; release restarts from DISARMED.
- Sync: 2-flop synchroniser per door.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while sync output != door_stable[i] and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, door_stable[i] toggles on the next edge and the counter clears.
- Latency: a clean raw edge appears on door_stable after DEBOUNCE_CYCLES+2 edges; light follows 1 edge later.
- open_any = |(door_stable & ~door_mask), combinational from registered inputs; a door_mask change takes effect on the next edge.
- FSM (disarm has priority over every other condition in every state):
  - DISARMED:
    - arm & !open_any -> ARMED.
    - arm while open_any is ignored; stay DISARMED.
  - ARMED:
    - disarm -> DISARMED.
    - open_any -> GRACE, timer loaded with OPEN_TIMEOUT-1.
    - arm is ignored.
  - GRACE:
    - disarm -> DISARMED.
    - else !open_any -> ARMED.
    - else timer==0 -> ALARM.
    - else timer decrements.
    - ALARM is entered exactly OPEN_TIMEOUT edges after GRACE entry if a door stays open.
  - ALARM:
    - disarm -> DISARMED.
    - Doors closing does not leave ALARM; arm is ignored.
- Timer width: $clog2(OPEN_TIMEOUT+1). It is loaded only on GRACE entry; there is no wrap.
- alarm_src:
  - On the ALARM-entry edge, loaded with door_stable & ~door_mask.
  - While in ALARM, ORed with door_stable & ~door_mask each cycle.
  - Cleared on DISARMED entry.
- alarm is registered; it equals (state==ALARM).
- arm and disarm asserted in the same cycle: disarm wins in all states.

Optional Feature:
- Macro: ALL_OPEN_ALARM_EN.
- Defined: if door_stable is all-ones (ignoring door_mask) while in ARMED or GRACE, go to ALARM on the next edge, bypassing the timer. disarm still has priority. alarm_src loads all-ones & ~door_mask.
- Undefined: no bypass; only the grace timer reaches ALARM.

Test Plan:
- Bench defaults for all tests: NUM_DOORS=4, DEBOUNCE_CYCLES=4, OPEN_TIMEOUT=8.
- Debounce: door_raw=0001 for 3 cycles, then 0000 -> door_stable stays 0000, light=0. door_raw=0100 held -> door_stable=0100 at edge 6, light=1 at edge 7.
- Grace to alarm: all closed, pulse arm -> state=01. Open door1 -> state=10 on the edge after door_stable[1] rises. Hold open -> state=11 and alarm=1 exactly 8 edges later, alarm_src=0010. Then open door3 -> alarm_src=1010.
- Grace abort: in GRACE, assert disarm at the 5th grace cycle -> state=00, alarm never 1. Separately, close door1 during GRACE -> state=01.
- Priority and mask:
  - arm and disarm together in ARMED -> state=00.
  - door_mask=1000, open door3 while ARMED -> state stays 01, light=0.
  - arm in DISARMED with door0 open -> state stays 00.
- Reset: in ALARM with alarm_src=0011, drop rst_n between clock edges -> alarm=0, alarm_src=0000, state=00, door_stable=0000 immediately, without waiting for an edge.
- ALL_OPEN_ALARM_EN defined: in ARMED, door_raw=1111 -> state=11 one edge after door_stable=1111, with no 8-cycle wait. With the macro undefined, the same stimulus waits 8 edges in GRACE.
